pipe_stage_reg: RTL and testbench

//   Generic inter-stage pipeline register for the 5-stage MIPS core (D->E, E->M, M->W).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline stage registers: NOP encoding,
// exception codes and data-lane indices.
package pipe_pkg;

  localparam int unsigned EXC_W = 5;

  localparam logic [31:0] INS_NOP = 32'h0000_0000;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam int unsigned LANE_V1  = 0;
  localparam int unsigned LANE_V2  = 1;
  localparam int unsigned LANE_EXT = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones, cleared by
// the synchronous active-high reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D->E, E->M, M->W) with hold/bubble/flush.
// Define PIPE_PERF_CNT_EN to add the stall/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned EXC_W     = pipe_pkg::EXC_W,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hold,
  input  logic                        bubble,
  input  logic                        flush,
  input  logic                        valid_i,
  input  logic [31:0]                 ins_i,
  input  logic [NUM_LANES*DATA_W-1:0] lane_i,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 pc8_i,
  input  logic [EXC_W-1:0]            exc_i,
  input  logic                        bd_i,
  output logic                        valid_o,
  output logic [31:0]                 ins_o,
  output logic [NUM_LANES*DATA_W-1:0] lane_o,
  output logic [31:0]                 pc_o,
  output logic [31:0]                 pc8_o,
  output logic [EXC_W-1:0]            exc_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [CNT_W-1:0]            bubble_cnt_o,
`endif
  output logic                        bd_o
);

  localparam int unsigned LW = NUM_LANES * DATA_W;

  logic          valid_d, valid_q;
  logic [31:0]   ins_d, ins_q;
  logic [LW-1:0] lane_d, lane_q;
  logic [31:0]   pc_d, pc_q;
  logic [31:0]   pc8_d, pc8_q;
  logic [EXC_W-1:0] exc_d, exc_q;
  logic          bd_d, bd_q;

  // Next stage contents, priority flush > hold > bubble > load.
  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    lane_d  = lane_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (flush) begin
      valid_d = 1'b0;
      ins_d   = 32'h0000_0000;
      lane_d  = {LW{1'b0}};
      pc_d    = 32'h0000_0000;
      pc8_d   = 32'h0000_0000;
      exc_d   = {EXC_W{1'b0}};
      bd_d    = 1'b0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (bubble) begin
      // PC/BD keep flowing so an exception on the bubble reports correct EPC/BD.
      valid_d = 1'b0;
      ins_d   = INS_NOP;
      lane_d  = {LW{1'b0}};
      pc_d    = pc_i;
      pc8_d   = 32'h0000_0000;
      exc_d   = {EXC_W{1'b0}};
      bd_d    = bd_i;
    end else begin
      valid_d = valid_i;
      ins_d   = ins_i;
      lane_d  = lane_i;
      pc_d    = pc_i;
      pc8_d   = pc8_i;
      exc_d   = exc_i;
      bd_d    = bd_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ins_q   <= 32'h0000_0000;
      lane_q  <= {LW{1'b0}};
      pc_q    <= 32'h0000_0000;
      pc8_q   <= 32'h0000_0000;
      exc_q   <= {EXC_W{1'b0}};
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      lane_q  <= lane_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign valid_o = valid_q;
  assign ins_o   = ins_q;
  assign lane_o  = lane_q;
  assign pc_o    = pc_q;
  assign pc8_o   = pc8_q;
  assign exc_o   = exc_q;
  assign bd_o    = bd_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc_s;
  logic bubble_inc_s;

  assign stall_inc_s  = hold & ~flush;
  assign bubble_inc_s = bubble & ~hold & ~flush;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .cnt   (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc_s),
    .cnt   (bubble_cnt_o)
  );
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed cases then random control mix,
// expected stage state from a behavioural model; counters checked when enabled.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NL     = 3;
  localparam int unsigned LW     = DATA_W * NL;
  localparam int unsigned CNT_W  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1, hold = 1'b0, bubble = 1'b0, flush = 1'b0;
  logic          valid_i = 1'b0, bd_i = 1'b0;
  logic [31:0]   ins_i = 32'h0, pc_i = 32'h0, pc8_i = 32'h0;
  logic [LW-1:0] lane_i = '0;
  logic [4:0]    exc_i = 5'd0;
  logic          valid_o, bd_o;
  logic [31:0]   ins_o, pc_o, pc8_o;
  logic [LW-1:0] lane_o;
  logic [4:0]    exc_o;
  logic [CNT_W-1:0] stall_cnt_s, bubble_cnt_s;

  typedef struct {
    logic          valid;
    logic [31:0]   ins;
    logic [LW-1:0] lane;
    logic [31:0]   pc;
    logic [31:0]   pc8;
    logic [4:0]    exc;
    logic          bd;
    int            stalls;
    int            bubbles;
  } exp_t;

  exp_t m;
  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_LANES(NL), .EXC_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .valid_i(valid_i), .ins_i(ins_i), .lane_i(lane_i), .pc_i(pc_i), .pc8_i(pc8_i),
    .exc_i(exc_i), .bd_i(bd_i),
    .valid_o(valid_o), .ins_o(ins_o), .lane_o(lane_o), .pc_o(pc_o), .pc8_o(pc8_o),
    .exc_o(exc_o),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_s), .bubble_cnt_o(bubble_cnt_s),
`endif
    .bd_o(bd_o)
  );

`ifndef PIPE_PERF_CNT_EN
  assign stall_cnt_s  = '0;
  assign bubble_cnt_s = '0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at negedge and record what the stage must hold afterwards.
  task automatic cyc(input logic r, input logic f, input logic h, input logic b,
                     input logic v, input logic [31:0] ins, input logic [LW-1:0] lane,
                     input logic [31:0] pc, input logic [31:0] pc8, input logic [4:0] exc,
                     input logic bd);
    int sat;
    @(negedge clk);
    reset = r; flush = f; hold = h; bubble = b;
    valid_i = v; ins_i = ins; lane_i = lane; pc_i = pc; pc8_i = pc8; exc_i = exc; bd_i = bd;
    sat = (1 << CNT_W) - 1;
    if (r) begin
      m = '{1'b0, 32'h0, '0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0};
    end else if (f) begin
      m = '{1'b0, 32'h0, '0, 32'h0, 32'h0, 5'd0, 1'b0, m.stalls, m.bubbles};
    end else if (h) begin
      if (m.stalls < sat) m.stalls++;
    end else if (b) begin
      m = '{1'b0, 32'h0, '0, pc, 32'h0, 5'd0, bd, m.stalls, m.bubbles};
      if (m.bubbles < sat) m.bubbles++;
    end else begin
      m = '{v, ins, lane, pc, pc8, exc, bd, m.stalls, m.bubbles};
    end
    expq.push_back(m);
  endtask

  function automatic logic [LW-1:0] rnd_lane();
    logic [LW-1:0] l;
    for (int k = 0; k < NL; k++) l[k*DATA_W +: DATA_W] = $urandom;
    return l;
  endfunction

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("valid_o", {127'b0, valid_o}, {127'b0, e.valid});
        chk("ins_o",   {96'b0, ins_o},    {96'b0, e.ins});
        chk("lane_o",  {32'b0, lane_o},   {32'b0, e.lane});
        chk("pc_o",    {96'b0, pc_o},     {96'b0, e.pc});
        chk("pc8_o",   {96'b0, pc8_o},    {96'b0, e.pc8});
        chk("exc_o",   {123'b0, exc_o},   {123'b0, e.exc});
        chk("bd_o",    {127'b0, bd_o},    {127'b0, e.bd});
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_o",  {124'b0, stall_cnt_s},  128'(e.stalls));
        chk("bubble_cnt_o", {124'b0, bubble_cnt_s}, 128'(e.bubbles));
`endif
      end
    end
  end

  initial begin
    logic [LW-1:0] l0;
    m = '{1'b0, 32'h0, '0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0};
    l0 = rnd_lane();
    // reset, load, bubble
    cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF, l0, 32'h1, 32'h9, 5'd3, 1);
    cyc(0, 0, 0, 0, 1, 32'h2108_0001, l0, 32'h3000, 32'h3008, 5'd0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_1021, rnd_lane(), 32'h3004, 32'h300C, 5'd10, 1);
    cyc(0, 0, 0, 0, 1, 32'h0000_1021, l0, 32'h3008, 32'h3010, 5'd4, 0);
    // hold three cycles with changing inputs, then hold+bubble
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 1, $urandom, rnd_lane(), $urandom, $urandom, 5'($urandom), 1'($urandom));
    cyc(0, 0, 1, 1, 1, $urandom, rnd_lane(), $urandom, $urandom, 5'd7, 1);
    // load an overflow exception, then flush while downstream holds
    cyc(0, 0, 0, 0, 1, 32'h0123_4567, rnd_lane(), 32'h4000, 32'h4008, 5'd12, 1);
    cyc(0, 1, 1, 0, 1, $urandom, rnd_lane(), $urandom, $urandom, 5'd12, 1);
    // reload, hold long enough to saturate the stall counter, reset mid-hold
    cyc(0, 0, 0, 0, 1, 32'h8C41_0004, rnd_lane(), 32'h5000, 32'h5008, 5'd5, 0);
    for (int i = 0; i < 20; i++)
      cyc(0, 0, 1, 0, 0, $urandom, rnd_lane(), $urandom, $urandom, 5'($urandom), 1'($urandom));
    cyc(1, 0, 1, 0, 1, $urandom, rnd_lane(), $urandom, $urandom, 5'd1, 1);
    cyc(0, 0, 1, 0, 1, $urandom, rnd_lane(), $urandom, $urandom, 5'd1, 1);
    // random control mix
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 20),
          1'($urandom), $urandom, rnd_lane(), $urandom, $urandom, 5'($urandom), 1'($urandom));
    end
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (expq.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
